mtr_drv: RTL and testbench
==========================

MTR_DRV -- requirements
Module: mtr_drv

Interface
REQ-001 SHALL have parameter NONOVERLAP, default 32, meaning dead-time in clocks both gate outputs of a side are low after each raw PWM edge.
REQ-002 SHALL have parameter BLANK, default 128, meaning count value below which overcurrent inputs are ignored in each PWM period.
REQ-003 SHALL have parameter FAULT_LIMIT, default 4, meaning consecutive faulted PWM periods that force shutdown.
REQ-004 SHALL have port clk, input, 1 bit: system clock, all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port lft_spd, input, 12 bits, signed: left wheel speed command from the Segway math stage.
REQ-007 SHALL have port rght_spd, input, 12 bits, signed: right wheel speed command.
REQ-008 SHALL have port OVR_I_lft, input, 1 bit: left bridge overcurrent comparator, active high, asynchronous to PWM.
REQ-009 SHALL have port OVR_I_rght, input, 1 bit: right bridge overcurrent comparator, active high.
REQ-010 SHALL have port PWM1_lft, output, 1 bit: left high-side gate drive.
REQ-011 SHALL have port PWM2_lft, output, 1 bit: left low-side gate drive.
REQ-012 SHALL have port PWM1_rght, output, 1 bit: right high-side gate drive.
REQ-013 SHALL have port PWM2_rght, output, 1 bit: right low-side gate drive.
REQ-014 SHALL have port PWM_synch, output, 1 bit: single-clock pulse when the period counter equals 0.
REQ-015 SHALL have port OVR_I_shtdwn, output, 1 bit: latched overcurrent shutdown flag.

Function
REQ-016 SHALL run one 11-bit free-running period counter, cnt, incrementing every clock and wrapping 2047 -> 0, giving a period of 2048 clocks.
REQ-017 SHALL assert PWM_synch combinationally while cnt == 0.
REQ-018 SHALL map each speed to an 11-bit duty: duty = {~spd[11], spd[10:1]}, so -2048 -> 0, 0 -> 1024, +2047 -> 2047.
REQ-019 SHALL capture each side's duty into a holding register only on the clock where cnt == 0; mid-period speed changes SHALL NOT alter the current period.
REQ-020 SHALL register a per-side raw PWM each clock as raw <= (cnt < duty_q).
REQ-021 SHALL drive both gate outputs of a side low for exactly NONOVERLAP clocks after every change of that side's raw PWM, using a per-side dead-time counter cleared on each change and saturating at NONOVERLAP.
REQ-022 Once dead-time expires, PWM1 SHALL follow raw and PWM2 SHALL follow ~raw; PWM1 and PWM2 of a side SHALL never be high together.
REQ-023 A raw pulse shorter than NONOVERLAP SHALL produce no gate pulse; both outputs stay low until stable.
REQ-024 With duty_q == 0 the side SHALL settle to PWM2 constantly high; with duty_q == 2047, PWM1 SHALL be high except a low window of 1 + NONOVERLAP clocks per period.
REQ-025 SHALL double-flop OVR_I_lft and OVR_I_rght before use.
REQ-026 A side's synchronised OVR_I SHALL qualify only when that side's raw is high and cnt >= BLANK.
REQ-027 SHALL set a period-fault flag on any qualified OVR_I of either side, and evaluate and clear it at each cnt == 0.
REQ-028 At each cnt == 0, a set flag SHALL increment a 3-bit consecutive-fault counter and a clear flag SHALL reset it to 0.
REQ-029 SHALL implement states RUN and SHTDWN; RUN -> SHTDWN when the counter reaches FAULT_LIMIT; SHTDWN SHALL be exited only by reset.
REQ-030 In SHTDWN, all four gate outputs SHALL be forced low the clock after entry and OVR_I_shtdwn SHALL be 1; cnt and PWM_synch SHALL keep running.
REQ-031 A period-fault flag set and evaluated on the same cnt == 0 clock SHALL count toward the period just ending.

Reset
REQ-032 On rst_n low, asynchronously: cnt = 0; duty_q = 1024 on both sides; raw = 0; dead-time counters = 0; fault flag and counter = 0; state = RUN; all PWM outputs = 0; OVR_I_shtdwn = 0.
REQ-033 After reset release, gate outputs SHALL remain low for at least NONOVERLAP clocks.
REQ-034 Reset asserted mid-period or in SHTDWN SHALL return the block to the REQ-032 values immediately.

Verification
REQ-035 lft_spd = 0 -> duty 1024; PWM1_lft high 992 clocks and PWM2_lft high 992 clocks per period, two 32-clock all-low gaps.
REQ-036 rght_spd = -2048 -> PWM1_rght never high; PWM2_rght continuously high after the first period.
REQ-037 lft_spd stepped 0 -> 1000 at cnt = 500 -> current period unchanged; duty 1524 from the next cnt == 0.
REQ-038 OVR_I_lft pulsed only at cnt < 128 every period -> fault counter stays 0 and no shutdown.
REQ-039 OVR_I_rght held high across 4 consecutive periods with PWM1_rght active -> OVR_I_shtdwn = 1 and all gates low after the 4th cnt == 0; 3 faulted periods then 1 clean period -> counter = 0 and no shutdown.
REQ-040 Under random speeds, PWM1_x & PWM2_x == 0 on every clock, and reset asserted in SHTDWN -> all outputs 0 and OVR_I_shtdwn = 0.

Source files
------------

// File: rtl/mtr_drv.sv
// Dual H-bridge gate driver: 2048-clock PWM with dead-time on each side and
// blanked overcurrent monitoring that latches a shutdown after repeated faulted periods.
module mtr_drv #(
  parameter int NONOVERLAP  = 32,
  parameter int BLANK       = 128,
  parameter int FAULT_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [11:0] lft_spd,
  input  logic signed [11:0] rght_spd,
  input  logic               OVR_I_lft,
  input  logic               OVR_I_rght,
  output logic               PWM1_lft,
  output logic               PWM2_lft,
  output logic               PWM1_rght,
  output logic               PWM2_rght,
  output logic               PWM_synch,
  output logic               OVR_I_shtdwn
);

  localparam int             NSIDE    = 2;
  localparam int             DTW      = (NONOVERLAP < 1) ? 1 : $clog2(NONOVERLAP + 1);
  localparam logic [DTW-1:0] DT_SAT   = DTW'(NONOVERLAP);
  localparam logic [11:0]    BLANK_W  = 12'(BLANK);
  localparam logic [10:0]    DUTY_MID = 11'd1024;

  typedef enum logic {RUN = 1'b0, SHTDWN = 1'b1} state_t;

  logic [10:0]      cnt_reg;
  logic             synch;
  logic             blank_ok;
  logic [11:0]      spd [NSIDE];
  logic [NSIDE-1:0] ovr_in;
  logic [NSIDE-1:0] ovr_meta_reg;
  logic [NSIDE-1:0] ovr_sync_reg;
  logic [NSIDE-1:0] qual;
  logic [NSIDE-1:0] pwm1;
  logic [NSIDE-1:0] pwm2;

  state_t     state_reg;
  logic       flag_reg;
  logic       shtdwn_reg;
  logic [2:0] fcnt_reg;
  logic [2:0] fcnt_next;
  logic       fault_eval;
  logic       limit_hit;

  // Period counter and frame marker, shared by both sides.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 11'd1;
    end
  end

  assign synch    = (cnt_reg == 11'd0);
  assign blank_ok = ({1'b0, cnt_reg} >= BLANK_W);

  assign spd[0] = lft_spd;
  assign spd[1] = rght_spd;
  assign ovr_in = {OVR_I_rght, OVR_I_lft};

  // Comparator inputs are asynchronous to clk; two flops before any use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_meta_reg <= '0;
      ovr_sync_reg <= '0;
    end else begin
      ovr_meta_reg <= ovr_in;
      ovr_sync_reg <= ovr_meta_reg;
    end
  end

  for (genvar gi = 0; gi < NSIDE; gi++) begin : g_side
    logic [10:0]    duty;
    logic [10:0]    duty_reg;
    logic           raw_reg;
    logic           raw_next;
    logic           raw_chg;
    logic [DTW-1:0] dt_reg;
    logic [DTW-1:0] dt_next;
    logic           gate_en;
    logic           pwm1_reg;
    logic           pwm2_reg;

    // Offset-binary view of the signed command: -2048 -> 0, 0 -> 1024, 2047 -> 2047.
    assign duty     = {~spd[gi][11], spd[gi][10:1]};
    assign raw_next = (cnt_reg < duty_reg);
    assign raw_chg  = (raw_next != raw_reg);

    always_comb begin
      dt_next = dt_reg;
      if (raw_chg) begin
        dt_next = '0;
      end else if (dt_reg < DT_SAT) begin
        dt_next = dt_reg + DTW'(1);
      end
    end

    // A gate opens only once raw has held its level for the whole dead-time,
    // so raw pulses shorter than that never reach the bridge.
    assign gate_en = (dt_next == DT_SAT) && (state_reg == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        duty_reg <= DUTY_MID;
        raw_reg  <= 1'b0;
        dt_reg   <= '0;
        pwm1_reg <= 1'b0;
        pwm2_reg <= 1'b0;
      end else begin
        if (synch) begin
          duty_reg <= duty;
        end
        raw_reg  <= raw_next;
        dt_reg   <= dt_next;
        pwm1_reg <= gate_en & raw_next;
        pwm2_reg <= gate_en & ~raw_next;
      end
    end

    assign pwm1[gi] = pwm1_reg;
    assign pwm2[gi] = pwm2_reg;
    assign qual[gi] = ovr_sync_reg[gi] & raw_reg & blank_ok;
  end

  // A qualifying event on the frame-marker clock still belongs to the period ending there.
  assign fault_eval = flag_reg | (|qual);

  always_comb begin
    fcnt_next = 3'd0;
    if (fault_eval) begin
      fcnt_next = (fcnt_reg == 3'd7) ? fcnt_reg : fcnt_reg + 3'd1;
    end
  end

  assign limit_hit = (int'(fcnt_next) >= FAULT_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= RUN;
      flag_reg   <= 1'b0;
      fcnt_reg   <= 3'd0;
      shtdwn_reg <= 1'b0;
    end else begin
      if (synch) begin
        flag_reg <= 1'b0;
        fcnt_reg <= fcnt_next;
      end else if (|qual) begin
        flag_reg <= 1'b1;
      end
      case (state_reg)
        RUN: begin
          if (synch && limit_hit) begin
            state_reg  <= SHTDWN;
            shtdwn_reg <= 1'b1;
          end
        end
        SHTDWN: begin
          shtdwn_reg <= 1'b1;
        end
      endcase
    end
  end

  assign PWM1_lft     = pwm1[0];
  assign PWM2_lft     = pwm2[0];
  assign PWM1_rght    = pwm1[1];
  assign PWM2_rght    = pwm2[1];
  assign PWM_synch    = synch;
  assign OVR_I_shtdwn = shtdwn_reg;

endmodule

// File: tb/tb_mtr_drv.sv
// Directed bench for mtr_drv: per-period gate counts, duty capture timing,
// blanking, consecutive-fault shutdown and reset behaviour.
module tb_mtr_drv;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic signed [11:0] lft_spd = '0;
  logic signed [11:0] rght_spd = '0;
  logic               OVR_I_lft = 1'b0;
  logic               OVR_I_rght = 1'b0;
  logic               PWM1_lft, PWM2_lft, PWM1_rght, PWM2_rght, PWM_synch, OVR_I_shtdwn;

  int n_vec = 0;
  int n_miss = 0;
  int c_p1l, c_p2l, c_p1r, c_p2r, c_ovl, c_sync, sync_pos, sd_rise;

  // Speed table and hand-computed gate-high counts per 2048-clock period.
  int sp_l  [5] = '{0, 1000, 2047, -2048, -1000};
  int sp_r  [5] = '{-2048, -1, 100, 2047, 1};
  int e_p1l [5] = '{992, 1492, 2015, 0, 492};
  int e_p2l [5] = '{992, 492, 0, 2048, 1492};
  int e_p1r [5] = '{0, 991, 1042, 2015, 992};
  int e_p2r [5] = '{2048, 993, 942, 0, 992};

  always #5 clk = ~clk;

  mtr_drv #(.NONOVERLAP(32), .BLANK(128), .FAULT_LIMIT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lft_spd      (lft_spd),
    .rght_spd     (rght_spd),
    .OVR_I_lft    (OVR_I_lft),
    .OVR_I_rght   (OVR_I_rght),
    .PWM1_lft     (PWM1_lft),
    .PWM2_lft     (PWM2_lft),
    .PWM1_rght    (PWM1_rght),
    .PWM2_rght    (PWM2_rght),
    .PWM_synch    (PWM_synch),
    .OVR_I_shtdwn (OVR_I_shtdwn)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic wait_synch();
    int n = 0;
    while (!PWM_synch && n < 4096) begin
      @(negedge clk);
      n++;
    end
    chk("synch_found", int'(PWM_synch), 1);
  endtask

  // Called on the negedge where cnt == 0; samples 2048 negedges and returns
  // on the next cnt == 0. OVR windows are in cnt units, [lo, hi).
  task automatic run_period(input int l_lo, input int l_hi, input int r_lo, input int r_hi,
                            input int step_at = -1, input int step_val = 0);
    c_p1l = 0; c_p2l = 0; c_p1r = 0; c_p2r = 0; c_ovl = 0; c_sync = 0;
    sync_pos = -1; sd_rise = -1;
    for (int i = 0; i < 2048; i++) begin
      OVR_I_lft  = (i >= l_lo) && (i < l_hi);
      OVR_I_rght = (i >= r_lo) && (i < r_hi);
      if (i == step_at) lft_spd = 12'(step_val);
      c_p1l += int'(PWM1_lft);
      c_p2l += int'(PWM2_lft);
      c_p1r += int'(PWM1_rght);
      c_p2r += int'(PWM2_rght);
      if (PWM1_lft && PWM2_lft) c_ovl++;
      if (PWM1_rght && PWM2_rght) c_ovl++;
      if (PWM_synch) begin
        c_sync++;
        if (sync_pos < 0) sync_pos = i;
      end
      if (OVR_I_shtdwn && sd_rise < 0) sd_rise = i;
      @(negedge clk);
    end
    OVR_I_lft  = 1'b0;
    OVR_I_rght = 1'b0;
  endtask

  task automatic post_reset_window(input string tag);
    int hi = 0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (PWM1_lft | PWM2_lft | PWM1_rght | PWM2_rght) hi++;
    end
    chk(tag, hi, 0);
  endtask

  initial begin
    int sd_any;
    int ovl_tot;

    lft_spd  = 12'sd0;
    rght_spd = 12'sh800;
    repeat (4) @(negedge clk);
    chk("rst_gates", int'({PWM1_lft, PWM2_lft, PWM1_rght, PWM2_rght}), 0);
    chk("rst_synch", int'(PWM_synch), 1);
    chk("rst_shtdwn", int'(OVR_I_shtdwn), 0);

    rst_n = 1'b1;
    post_reset_window("post_rst_gates_high");
    wait_synch();

    // Steady-state gate counts for each speed pair; first period lets duty settle.
    for (int v = 0; v < 5; v++) begin
      lft_spd  = 12'(sp_l[v]);
      rght_spd = 12'(sp_r[v]);
      run_period(-1, -1, -1, -1);
      run_period(-1, -1, -1, -1);
      chk($sformatf("v%0d_p1l", v), c_p1l, e_p1l[v]);
      chk($sformatf("v%0d_p2l", v), c_p2l, e_p2l[v]);
      chk($sformatf("v%0d_p1r", v), c_p1r, e_p1r[v]);
      chk($sformatf("v%0d_p2r", v), c_p2r, e_p2r[v]);
      chk($sformatf("v%0d_overlap", v), c_ovl, 0);
    end
    chk("synch_count", c_sync, 1);
    chk("synch_pos", sync_pos, 0);

    // Mid-period speed step is held off until the next frame marker.
    lft_spd  = 12'sd0;
    rght_spd = 12'sd0;
    run_period(-1, -1, -1, -1);
    run_period(-1, -1, -1, -1, 500, 1000);
    chk("step_cur_p1l", c_p1l, 992);
    chk("step_cur_p2l", c_p2l, 992);
    run_period(-1, -1, -1, -1);
    chk("step_next_p1l", c_p1l, 1492);
    chk("step_next_p2l", c_p2l, 492);

    // Overcurrent inside the blanking window or while raw is low is ignored.
    lft_spd = 12'sd0;
    sd_any = 0;
    for (int p = 0; p < 5; p++) begin
      run_period(10, 100, 1500, 1700);
      if (sd_rise >= 0) sd_any = 1;
    end
    chk("blank_no_shtdwn", sd_any, 0);
    chk("blank_p1l", c_p1l, 992);

    // Random speeds, including mid-period changes: sides never shoot through.
    ovl_tot = 0;
    for (int p = 0; p < 3; p++) begin
      lft_spd  = 12'($urandom);
      rght_spd = 12'($urandom);
      run_period(-1, -1, -1, -1, int'($urandom_range(1, 2047)), int'($urandom_range(0, 4095)));
      ovl_tot += c_ovl;
    end
    chk("rand_overlap", ovl_tot, 0);

    // Three faulted periods, one clean, then four faulted -> shutdown.
    lft_spd  = 12'sd0;
    rght_spd = 12'sd0;
    run_period(-1, -1, -1, -1);
    sd_any = 0;
    for (int p = 0; p < 8; p++) begin
      if (p == 3) run_period(-1, -1, -1, -1);
      else        run_period(-1, -1, 200, 400);
      if (sd_rise >= 0) sd_any = 1;
    end
    chk("no_shtdwn_before_limit", sd_any, 0);
    run_period(-1, -1, -1, -1);
    chk("shtdwn_rise_cnt", sd_rise, 1);
    run_period(-1, -1, -1, -1);
    chk("shtdwn_gates_high", c_p1l + c_p2l + c_p1r + c_p2r, 0);
    chk("shtdwn_synch_count", c_sync, 1);
    chk("shtdwn_flag", int'(OVR_I_shtdwn), 1);

    // Reset from SHTDWN mid-period takes effect without a clock edge.
    repeat (700) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst2_gates", int'({PWM1_lft, PWM2_lft, PWM1_rght, PWM2_rght}), 0);
    chk("rst2_shtdwn", int'(OVR_I_shtdwn), 0);
    chk("rst2_synch", int'(PWM_synch), 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    post_reset_window("rst2_post_gates_high");
    wait_synch();
    run_period(-1, -1, -1, -1);
    chk("rst2_p1l", c_p1l, 992);
    chk("rst2_p2r", c_p2r, 992);
    chk("rst2_no_shtdwn", sd_rise, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
